mem_port_arbiter: RTL

- Shares one memory_interface instance between the core's instruction-fetch port (port I, read-only) and data-access port (port D, read/write).
- Sits between five_stage_cpu and a unified memory_interface inside chip.
- Accepts one transaction at a time and forwards it to memory as a single-cycle request pulse.
- Waits for the memory valid pulse and routes the response and valid to the granted requester.
- Provides a timeout watchdog for hung memory.

---
 rtl/mem_port_arbiter.sv | 83 ++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (I) and data access (D) requesters.
// Ports: clk, rst_n (sync, active-low); i_req/i_addr -> i_valid/i_rdata;
// d_req/d_we/d_addr/d_wdata -> d_valid/d_rdata; mem_request/mem_we/mem_addr/mem_wdata -> memory,
// mem_valid/mem_rdata <- memory; timeout_err sticky watchdog flag.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on collisions instead of fixed D-over-I priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_valid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_valid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_request,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  timeout_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic grant_d, any_req, win_d, start, done, tmo, fire;
  logic [CW-1:0] cnt;
  assign any_req = i_req | d_req;
  assign start   = (state == IDLE) && any_req;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;
  // On a collision the port that was not served last wins.
  assign win_d = d_req & (~i_req | ~last_d);
  always_ff @(posedge clk)
    if (!rst_n) last_d <= 1'b0;
    else if (start) last_d <= win_d;
`else
  assign win_d = d_req;
`endif
  // mem_valid during the request cycle cannot be ours: memory latency is at least one cycle.
  assign done = (state == BUSY) && !mem_request && mem_valid;
  assign tmo  = (state == BUSY) && !done && (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign fire = done | tmo;
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nx;
  always_comb
    state_nx = (state == IDLE) ? (any_req ? BUSY : IDLE) : (fire ? IDLE : BUSY);
  always_ff @(posedge clk)
    if (!rst_n) begin
      mem_request <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      grant_d     <= 1'b0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      mem_request <= start;
      if (start) begin
        grant_d   <= win_d;
        mem_we    <= win_d & d_we;
        mem_addr  <= win_d ? d_addr : i_addr;
        mem_wdata <= win_d ? d_wdata : '0;
      end
      cnt <= ((state == BUSY) && !fire) ? cnt + 1'b1 : '0;
      if (tmo) timeout_err <= 1'b1;
    end
  // A watchdog abort still strobes the requester, but with zero data.
  always_comb begin
    i_valid = fire & ~grant_d;
    d_valid = fire & grant_d;
    i_rdata = (i_valid && done) ? mem_rdata : '0;
    d_rdata = (d_valid && done && !mem_we) ? mem_rdata : '0;
  end
endmodule
